// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared types and constants for the matmul_ctrl sequencer.
//               Holds the controller state encoding, the reserved shift_cnt
//               value and a small index-width helper used by every file.
// Revision    : 1.0  initial release
// ============================================================================
package matmul_pkg;

    // Controller states, explicitly encoded so the state register width is fixed.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CLEAR  = 3'd3,
        S_MAC    = 3'd4,
        S_WRITE  = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    // Reserved output value; shift_cnt is never driven to anything else.
    localparam logic [1:0] SHIFT_CNT_DEFAULT = 2'b00;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_idx_cnt.sv
`default_nettype none
// ============================================================================
// Module      : matmul_idx_cnt
// Description : Nested i/j/k index counters for the matrix-multiply sequencer.
//               Each index has its own clear and step input and a wrap flag
//               that is high when the index holds its last value, so a step
//               in that condition returns the index to zero.
// Ports       : clk, rst            clock, asynchronous active-high reset
//               {i,j,k}_clear       force the index to zero
//               {i,j,k}_step        advance the index (wraps to zero)
//               idx_i/idx_j/idx_k   current index values
//               {i,j,k}_wrap        index is at its last value
// Revision    : 1.0  initial release
// ============================================================================
module matmul_idx_cnt
    import matmul_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_step,
    input  logic                   j_clear,
    input  logic                   j_step,
    input  logic                   k_clear,
    input  logic                   k_step,
    output logic [idx_w(M)-1:0]    idx_i,
    output logic [idx_w(M)-1:0]    idx_j,
    output logic [idx_w(N)-1:0]    idx_k,
    output logic                   i_wrap,
    output logic                   j_wrap,
    output logic                   k_wrap
);

    localparam int IW = idx_w(M);
    localparam int KW = idx_w(N);

    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [KW-1:0] r_k;

    assign i_wrap = (r_i == IW'(M - 1));
    assign j_wrap = (r_j == IW'(M - 1));
    assign k_wrap = (r_k == KW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else begin
            if (i_clear)     r_i <= '0;
            else if (i_step) r_i <= i_wrap ? '0 : r_i + IW'(1);

            if (j_clear)     r_j <= '0;
            else if (j_step) r_j <= j_wrap ? '0 : r_j + IW'(1);

            if (k_clear)     r_k <= '0;
            else if (k_step) r_k <= k_wrap ? '0 : r_k + KW'(1);
        end
    end

    assign idx_i = r_i;
    assign idx_j = r_j;
    assign idx_k = r_k;

endmodule
`default_nettype wire

// File: rtl/matmul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matmul_ctrl
// Description : Sequencer for a memory-based matrix multiply C = A x B with
//               A (M x N), B (N x M), C (M x M), all stored row-major.
//               Loads A then B from a valid-qualified input stream, then for
//               each C element clears the accumulator, runs N MAC cycles and
//               writes the result.
// Ports       : clk, rst              clock, asynchronous active-high reset
//               start, in_valid       job request, load-beat qualifier
//               busy, done            job in progress, one-cycle completion
//               m{1,2,3}{,r,w}EN      memory enables for A, B, C
//               addr1/addr2/addr3     memory addresses for A, B, C
//               mult_ld, mult_rst     accumulator load / clear
//               shift_cnt             reserved, always 2'b00
//               cycle_cnt             busy-cycle counter (MATMUL_CTRL_PERF_EN)
// Options     : define MATMUL_CTRL_PERF_EN to add the cycle_cnt output.
// Revision    : 1.0  initial release
// ============================================================================
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int M  = 8,
    parameter int N  = 8,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          busy,
    output logic          done,
    output logic          m1EN,
    output logic          m1rEN,
    output logic          m1wEN,
    output logic          m2EN,
    output logic          m2rEN,
    output logic          m2wEN,
    output logic          m3EN,
    output logic          m3rEN,
    output logic          m3wEN,
    output logic [AW-1:0] addr1,
    output logic [AW-1:0] addr2,
    output logic [AW-1:0] addr3,
    output logic          mult_ld,
    output logic          mult_rst,
    output logic [1:0]    shift_cnt
`ifdef MATMUL_CTRL_PERF_EN
    ,
    output logic [31:0]   cycle_cnt
`endif
);

    localparam int IW = idx_w(M);
    localparam int KW = idx_w(N);
    localparam int LW = idx_w(M * N);

    // A load index beyond the address space would silently alias.
    if (longint'(M) * longint'(N) > (longint'(1) << AW)) begin : g_cfg_check
        $error("matmul_ctrl: M*N exceeds the 2**AW address space");
    end

    state_e        r_state;
    state_e        w_state_nxt;
    logic [LW-1:0] r_ld_idx;
    logic [IW-1:0] w_i;
    logic [IW-1:0] w_j;
    logic [KW-1:0] w_k;
    logic          w_i_wrap;
    logic          w_j_wrap;
    logic          w_k_wrap;
    logic          w_beat_a;
    logic          w_beat_b;
    logic          w_last_ld;
    logic          w_accept;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_beat_a  = (r_state == S_LOAD_A) && in_valid;
    assign w_beat_b  = (r_state == S_LOAD_B) && in_valid;
    assign w_last_ld = (r_ld_idx == LW'(M * N - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_LOAD_A;
            S_LOAD_A: if (w_beat_a && w_last_ld) w_state_nxt = S_LOAD_B;
            S_LOAD_B: if (w_beat_b && w_last_ld) w_state_nxt = S_CLEAR;
            S_CLEAR:  w_state_nxt = S_MAC;
            S_MAC:    if (w_k_wrap) w_state_nxt = S_WRITE;
            S_WRITE:  w_state_nxt = (w_i_wrap && w_j_wrap) ? S_DONE : S_CLEAR;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Load beat index is shared by A and B; it returns to zero after each
    // matrix so B starts at address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_idx <= '0;
        end else if (w_beat_a || w_beat_b) begin
            r_ld_idx <= w_last_ld ? '0 : r_ld_idx + LW'(1);
        end else if (w_accept) begin
            r_ld_idx <= '0;
        end
    end

    matmul_idx_cnt #(
        .M (M),
        .N (N)
    ) u_idx_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_beat_b && w_last_ld),
        .i_step  ((r_state == S_WRITE) && w_j_wrap),
        .j_clear (w_beat_b && w_last_ld),
        .j_step  (r_state == S_WRITE),
        .k_clear (r_state == S_CLEAR),
        .k_step  (r_state == S_MAC),
        .idx_i   (w_i),
        .idx_j   (w_j),
        .idx_k   (w_k),
        .i_wrap  (w_i_wrap),
        .j_wrap  (w_j_wrap),
        .k_wrap  (w_k_wrap)
    );

    always_comb begin
        m1EN     = 1'b0;
        m1rEN    = 1'b0;
        m1wEN    = 1'b0;
        m2EN     = 1'b0;
        m2rEN    = 1'b0;
        m2wEN    = 1'b0;
        m3EN     = 1'b0;
        m3rEN    = 1'b0;
        m3wEN    = 1'b0;
        addr1    = '0;
        addr2    = '0;
        addr3    = '0;
        mult_ld  = 1'b0;
        // The accumulator is held clear while reset is asserted.
        mult_rst = rst;
        case (r_state)
            S_LOAD_A: begin
                m1EN  = in_valid;
                m1wEN = in_valid;
                addr1 = AW'(r_ld_idx);
            end
            S_LOAD_B: begin
                m2EN  = in_valid;
                m2wEN = in_valid;
                addr2 = AW'(r_ld_idx);
            end
            S_CLEAR: begin
                mult_rst = 1'b1;
            end
            S_MAC: begin
                m1EN    = 1'b1;
                m1rEN   = 1'b1;
                m2EN    = 1'b1;
                m2rEN   = 1'b1;
                mult_ld = 1'b1;
                addr1   = AW'(w_i) * AW'(N) + AW'(w_k);
                addr2   = AW'(w_k) * AW'(M) + AW'(w_j);
            end
            S_WRITE: begin
                m3EN  = 1'b1;
                m3wEN = 1'b1;
                addr3 = AW'(w_i) * AW'(M) + AW'(w_j);
            end
            default: ;
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign shift_cnt = SHIFT_CNT_DEFAULT;

`ifdef MATMUL_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
        end else if (w_accept) begin
            r_cycle_cnt <= '0;
        end else if (busy && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`endif

endmodule
`default_nettype wire
